dino_game_core: RTL and testbench
=================================

# dino_game_core

Game-logic core of the dinosaur runner, sitting between raw board inputs and the VGA renderer. It debounces the 16 switches and the jump button, runs the start/stop and jump state machine (dinosaur height), and scrolls the ground at an accelerating speed. It also produces a combinational per-pixel "ground" flag for the current VGA scan address.

## Interface
- DEBOUNCE_BITS, 4: debounce counter width; an input must differ from its output for 2^DEBOUNCE_BITS consecutive cycles to be accepted.
- JUMP_DIV, 500000: CLK cycles per jump-physics tick.
- GROUND_DIV, 250000: CLK cycles per ground-scroll tick.
- MAX_HEIGHT, 48: jump apex height (1..63).
- SPEEDUP_STEPS, 256: ground ticks per speed increment.
- CLK  in  1  single clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- SW  in  16  raw switches.
- BTN_JUMP  in  1  raw jump button, active high.
- hit  in  1  collision flag from renderer, active high, sampled synchronously.
- row_addr  in  9  VGA row of current pixel.
- col_addr  in  10  VGA column of current pixel.
- SW_OK  out  16  debounced switches.
- dinosaur_height  out  6  dinosaur height above ground.
- game_status  out  1  1 = running, 0 = stopped.
- speed  out  4  ground scroll pixels per ground tick.
- ground_position  out  10  scroll offset, 0..639.
- px_ground  out  1  current pixel is ground (combinational).

## Operation
- Debounce (17 identical channels: SW[15:0], BTN_JUMP): per channel, an N-bit counter and output O. If input == O, counter <= 0. Otherwise counter increments; when counter == 2^N-1 and input still differs, O <= input and counter <= 0.
- Button edge: btn_ok is registered into btn_d; press = btn_ok & ~btn_d.
- Prescalers: two free-running 32-bit counters count 0..DIV-1 and wrap. jump_tick / ground_tick are high for the single cycle where the counter == DIV-1.
- Game control:
  - hit while running -> game_status <= 0. All motion freezes; height, speed and position hold.
  - press while stopped -> game_status <= 1, speed <= 1, dinosaur_height <= 0, jump FSM <= IDLE, speedup count <= 0.
  - The start press does not begin a jump.
  - If hit and press occur in the same cycle, hit wins.
- Jump FSM (advances only while running):
  - IDLE: height 0; press -> RISE.
  - RISE: on each jump_tick, height += 1; the tick that makes height == MAX_HEIGHT moves to FALL.
  - FALL: on each jump_tick, height -= 1; the tick that makes height == 0 moves to IDLE.
  - Presses during RISE/FALL are ignored (no double jump).
- Ground (advances only while running):
  - On each ground_tick, ground_position <= (ground_position + speed) mod 640, computed in 11 bits.
  - A speedup counter counts ground ticks; on the SPEEDUP_STEPS-th tick, speed <= min(speed+1, 15) and the counter clears.
- px_ground = 1 iff row_addr < 480, col_addr < 640, and either:
  - row_addr == 400, or
  - row_addr in 404..405 and bits [4:3] of x == 2'b00, where x = (col_addr + ground_position) mod 640.

## Timing
- Reset (clrn = 0, asynchronous): SW_OK = 0, debounced button = 0, btn_d = 0, dinosaur_height = 0, game_status = 0, speed = 0, ground_position = 0, FSM = IDLE, prescalers = 0, speedup count = 0.
- Reset mid-jump or mid-debounce clears everything immediately.
- Debounce latency: an input held stable from edge k first appears on O after edge k + 2^N - 1. Any glitch back to O before then restarts the count.
- Press to state change: 1 cycle after btn_ok rises. A height change waits for the next jump_tick.
- First tick after reset arrives on cycle DIV (counter == DIV-1).
- px_ground has zero latency from row/col inputs and reflects the registered ground_position.

## Test plan
All scenarios use DEBOUNCE_BITS=2, JUMP_DIV=2, GROUND_DIV=2, MAX_HEIGHT=4, SPEEDUP_STEPS=4.
- Debounce: SW[0] pulses high for 3 cycles -> SW_OK[0] stays 0. SW[0] held high for 4 cycles -> SW_OK[0] = 1 after the 4th edge; other bits stay 0.
- Start: press BTN_JUMP from reset -> game_status = 1, speed = 1, height stays 0. ground_position steps 1, 2, 3 on successive ground ticks.
- Jump: second press while running -> height follows 1, 2, 3, 4, 3, 2, 1, 0 on jump ticks, then IDLE. A press during the jump does not extend it.
- Speed: after 4 ground ticks, speed = 2; position increments by 2 per tick. Speed saturates at 15.
- Wrap: force ground_position = 639 with speed 2 -> next tick gives 1. px_ground: row 400 col 0 -> 1; row 404 col 8 at position 0 -> 0; row 404 col 0 -> 1; row 480 -> 0.
- Hit: assert hit mid-jump at height 2 -> game_status = 0; height, speed and position frozen. Hit and press in the same cycle -> stays stopped. clrn low mid-jump -> all outputs 0 immediately.

Source files
------------

// File: rtl/dino_game_core.sv
// Game-logic core of the dinosaur runner: input debouncing, start/stop and
// jump control, accelerating ground scroll and the per-pixel ground flag.
module dino_game_core #(
    parameter int DEBOUNCE_BITS = 4,
    parameter int JUMP_DIV      = 500000,
    parameter int GROUND_DIV    = 250000,
    parameter int MAX_HEIGHT    = 48,
    parameter int SPEEDUP_STEPS = 256
) (
    input  logic        CLK,
    input  logic        clrn,
    input  logic [15:0] SW,
    input  logic        BTN_JUMP,
    input  logic        hit,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    output logic [15:0] SW_OK,
    output logic [5:0]  dinosaur_height,
    output logic        game_status,
    output logic [3:0]  speed,
    output logic [9:0]  ground_position,
    output logic        px_ground
);

    localparam int CHANNELS = 17;
    localparam int SC_W     = $clog2(SPEEDUP_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } jump_state_t;

    // Debounce: switches in the low 16 channels, jump button on top.
    logic [CHANNELS-1:0]      raw_in;
    logic [CHANNELS-1:0]      deb_out;
    logic [DEBOUNCE_BITS-1:0] deb_cnt [CHANNELS];

    assign raw_in = {BTN_JUMP, SW};
    assign SW_OK  = deb_out[15:0];

    logic btn_ok;
    logic btn_d;
    logic press;

    assign btn_ok = deb_out[16];
    assign press  = btn_ok & ~btn_d;

    // Per-channel debounce: accept a new level only after it has differed
    // from the output for 2^DEBOUNCE_BITS consecutive cycles.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            deb_out <= '0;
            // NOTE: the counter array is plain flops, not a RAM, so every entry is cleared by the async reset.
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (raw_in[i] == deb_out[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == '1) begin
                    deb_out[i] <= raw_in[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced button for rising-edge detection.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            btn_d <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            btn_d <= btn_ok;
        end
    end

    // Free-running prescalers producing single-cycle physics/scroll ticks.
    logic [31:0] jump_cnt;
    logic [31:0] ground_cnt;
    logic        jump_tick;
    logic        ground_tick;

    assign jump_tick   = (jump_cnt == 32'(JUMP_DIV - 1));
    assign ground_tick = (ground_cnt == 32'(GROUND_DIV - 1));

    // Prescaler counters wrap at DIV-1.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            jump_cnt   <= '0;
            ground_cnt <= '0;
        end else begin
            jump_cnt   <= jump_tick   ? '0 : jump_cnt + 32'd1;
            ground_cnt <= ground_tick ? '0 : ground_cnt + 32'd1;
        end
    end

    // Game state and its next-state values.
    jump_state_t state, state_next;
    logic [5:0]  height_next;
    logic        status_next;
    logic [3:0]  speed_next;
    logic [9:0]  pos_next;
    logic [SC_W-1:0] sc_cnt, sc_next;
    logic [10:0] pos_sum;

    // Game state register.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state           <= IDLE;
            dinosaur_height <= '0;
            game_status     <= 1'b0;
            speed           <= '0;
            ground_position <= '0;
            sc_cnt          <= '0;
        end else begin
            state           <= state_next;
            dinosaur_height <= height_next;
            game_status     <= status_next;
            speed           <= speed_next;
            ground_position <= pos_next;
            sc_cnt          <= sc_next;
        end
    end

    // Start/stop control, jump FSM and ground scroll; motion only while running.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        height_next = dinosaur_height;
        status_next = game_status;
        speed_next  = speed;
        pos_next    = ground_position;
        sc_next     = sc_cnt;

        pos_sum = {1'b0, ground_position} + {7'd0, speed};
        if (pos_sum >= 11'd640) begin
            pos_sum = pos_sum - 11'd640;
        end

        if (game_status) begin
            if (hit) begin
                status_next = 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (press) begin
                            state_next = RISE;
                        end
                    end
                    RISE: begin
                        if (jump_tick) begin
                            height_next = dinosaur_height + 6'd1;
                            if (height_next == 6'(MAX_HEIGHT)) begin
                                state_next = FALL;
                            end
                        end
                    end
                    FALL: begin
                        if (jump_tick) begin
                            height_next = dinosaur_height - 6'd1;
                            if (height_next == 6'd0) begin
                                state_next = IDLE;
                            end
                        end
                    end
                    default: state_next = IDLE;
                endcase

                if (ground_tick) begin
                    pos_next = pos_sum[9:0];
                    if (sc_cnt == SC_W'(SPEEDUP_STEPS - 1)) begin
                        sc_next = '0;
                        if (speed != 4'd15) begin
                            speed_next = speed + 4'd1;
                        end
                    end else begin
                        sc_next = sc_cnt + 1'b1;
                    end
                end
            end
        end else if (press && !hit) begin
            status_next = 1'b1;
            speed_next  = 4'd1;
            height_next = 6'd0;
            state_next  = IDLE;
            sc_next     = '0;
        end
    end

    // Ground line at row 400 plus dashed texture on rows 404-405 that scrolls.
    logic [10:0] px_x;

    always_comb begin
        px_x = {1'b0, col_addr} + {1'b0, ground_position};
        if (px_x >= 11'd640) begin
            px_x = px_x - 11'd640;
        end
        px_ground = 1'b0;
        if (row_addr < 9'd480 && col_addr < 10'd640) begin
            if (row_addr == 9'd400) begin
                px_ground = 1'b1;
            end else if ((row_addr == 9'd404 || row_addr == 9'd405) && px_x[4:3] == 2'b00) begin
                px_ground = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dino_game_core.sv
// Self-checking bench for dino_game_core: directed scenarios plus random
// stimulus compared every cycle against a behavioural game model.
module tb_dino_game_core;

    localparam int DB = 2;
    localparam int JD = 2;
    localparam int GD = 2;
    localparam int MH = 4;
    localparam int SS = 4;

    logic        CLK = 1'b0;
    logic        clrn;
    logic [15:0] SW;
    logic        BTN_JUMP;
    logic        hit;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic [15:0] SW_OK;
    logic [5:0]  dinosaur_height;
    logic        game_status;
    logic [3:0]  speed;
    logic [9:0]  ground_position;
    logic        px_ground;

    dino_game_core #(
        .DEBOUNCE_BITS(DB),
        .JUMP_DIV(JD),
        .GROUND_DIV(GD),
        .MAX_HEIGHT(MH),
        .SPEEDUP_STEPS(SS)
    ) dut (
        .CLK(CLK),
        .clrn(clrn),
        .SW(SW),
        .BTN_JUMP(BTN_JUMP),
        .hit(hit),
        .row_addr(row_addr),
        .col_addr(col_addr),
        .SW_OK(SW_OK),
        .dinosaur_height(dinosaur_height),
        .game_status(game_status),
        .speed(speed),
        .ground_position(ground_position),
        .px_ground(px_ground)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    bit m_o   [17];
    int m_run [17];
    bit m_btn_d;
    bit m_running;
    int m_h;
    int m_phase;     // 0 on ground, 1 going up, 2 coming down
    int m_speed;
    int m_pos;
    int m_sc;
    int m_cyc;

    logic [15:0] cur_sw;
    int          prev_pos;
    bit          wrap_seen;

    task automatic m_reset();
        for (int i = 0; i < 17; i++) begin
            m_o[i]   = 1'b0;
            m_run[i] = 0;
        end
        m_btn_d = 0; m_running = 0; m_h = 0; m_phase = 0;
        m_speed = 0; m_pos = 0; m_sc = 0; m_cyc = 0;
        prev_pos = 0;
    endtask

    function automatic bit px_model(input int row, input int col, input int pos);
        int x;
        if (row >= 480 || col >= 640) return 1'b0;
        x = (col + pos) % 640;
        return (row == 400) || ((row == 404 || row == 405) && ((x / 8) % 4) == 0);
    endfunction

    // Advance the model by one rising clock edge using the current inputs.
    task automatic model_step();
        bit press;
        bit jt;
        bit gt;
        bit inb;
        press = m_o[16] && !m_btn_d;
        jt    = (m_cyc % JD) == JD - 1;
        gt    = (m_cyc % GD) == GD - 1;
        if (m_running) begin
            if (hit) begin
                m_running = 0;
            end else begin
                if (m_phase == 0 && press) begin
                    m_phase = 1;
                end else if (m_phase == 1 && jt) begin
                    m_h++;
                    if (m_h == MH) m_phase = 2;
                end else if (m_phase == 2 && jt) begin
                    m_h--;
                    if (m_h == 0) m_phase = 0;
                end
                if (gt) begin
                    m_pos = (m_pos + m_speed) % 640;
                    m_sc++;
                    if (m_sc == SS) begin
                        m_sc = 0;
                        if (m_speed < 15) m_speed++;
                    end
                end
            end
        end else if (press && !hit) begin
            m_running = 1; m_speed = 1; m_h = 0; m_phase = 0; m_sc = 0;
        end
        m_btn_d = m_o[16];
        for (int i = 0; i < 17; i++) begin
            inb = (i < 16) ? SW[i] : BTN_JUMP;
            if (inb != m_o[i]) begin
                m_run[i]++;
                if (m_run[i] == (1 << DB)) begin
                    m_o[i]   = inb;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [15:0] sw_exp;
        for (int i = 0; i < 16; i++) sw_exp[i] = m_o[i];
        check("sw_ok", SW_OK, sw_exp);
        check("height", dinosaur_height, m_h);
        check("status", game_status, m_running);
        check("speed", speed, m_speed);
        check("position", ground_position, m_pos);
    endtask

    task automatic rand_pixel();
        case ($urandom_range(0, 3))
            0: row_addr = 9'd400;
            1: row_addr = 9'd404;
            2: row_addr = 9'd405;
            default: row_addr = 9'($urandom_range(0, 511));
        endcase
        col_addr = 10'($urandom_range(0, 1023));
    endtask

    // One clock cycle: entered just after a falling edge, leaves at the next one.
    task automatic cycle(input logic btn, input logic h);
        SW       = cur_sw;
        BTN_JUMP = btn;
        hit      = h;
        rand_pixel();
        #1;
        check("px_ground", px_ground, px_model(row_addr, col_addr, m_pos));
        model_step();
        @(negedge CLK);
        compare_all();
        if (int'(ground_position) < prev_pos) wrap_seen = 1;
        prev_pos = ground_position;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int last;
        int exp_h [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        int exp_p [5] = '{1, 2, 3, 4, 6};

        clrn = 1'b0; cur_sw = '0; SW = '0; BTN_JUMP = 0; hit = 0;
        row_addr = '0; col_addr = '0; wrap_seen = 0;
        m_reset();
        @(negedge CLK);
        compare_all();
        check("rst_status", game_status, 0);
        check("rst_height", dinosaur_height, 0);
        check("rst_speed", speed, 0);
        check("rst_position", ground_position, 0);
        row_addr = 9'd400; col_addr = 10'd0; #1 check("px_r400_c0", px_ground, 1);
        row_addr = 9'd404; col_addr = 10'd8; #1 check("px_r404_c8", px_ground, 0);
        row_addr = 9'd404; col_addr = 10'd0; #1 check("px_r404_c0", px_ground, 1);
        row_addr = 9'd480; col_addr = 10'd0; #1 check("px_r480", px_ground, 0);
        @(negedge CLK);
        clrn = 1'b1;

        // Debounce: short pulse rejected, 4-cycle hold accepted.
        cur_sw = 16'h0001;
        repeat (3) cycle(0, 0);
        cur_sw = 16'h0000;
        repeat (3) cycle(0, 0);
        check("db_pulse", SW_OK, 16'h0000);
        cur_sw = 16'h0001;
        repeat (4) cycle(0, 0);
        check("db_hold", SW_OK, 16'h0001);

        // Start the game.
        repeat (5) cycle(1, 0);
        check("start_status", game_status, 1);
        check("start_speed", speed, 1);
        check("start_height", dinosaur_height, 0);
        last = 0;
        for (int i = 0; i < 40 && q.size() < 5; i++) begin
            cycle(0, 0);
            if (int'(ground_position) != last) begin
                last = ground_position;
                q.push_back(last);
            end
        end
        check("pos_steps", q.size(), 5);
        for (int i = 0; i < q.size() && i < 5; i++) check("pos_seq", q[i], exp_p[i]);
        check("speed_after4", speed, 2);

        // Jump with a second press in mid-air.
        q.delete();
        last = dinosaur_height;
        for (int i = 0; i < 60 && q.size() < 8; i++) begin
            cycle((i < 5) || (i >= 11 && i < 17), 0);
            if (int'(dinosaur_height) != last) begin
                last = dinosaur_height;
                q.push_back(last);
            end
        end
        check("jump_steps", q.size(), 8);
        for (int i = 0; i < q.size() && i < 8; i++) check("jump_seq", q[i], exp_h[i]);
        repeat (12) cycle(0, 0);
        check("no_double_jump", dinosaur_height, 0);

        // Long run: speed saturates and position wraps.
        for (int i = 0; i < 240; i++) cycle(((i / 8) % 4) == 0, 0);
        check("speed_sat", speed, 15);
        check("wrap_seen", wrap_seen, 1);

        // Hit mid-jump at height 2 freezes everything.
        for (int i = 0; i < 40 && dinosaur_height != 6'd2; i++) cycle(i < 5, 0);
        check("reach_h2", dinosaur_height, 2);
        cycle(0, 1);
        check("hit_status", game_status, 0);
        repeat (6) cycle(0, 0);
        check("hit_frozen_h", dinosaur_height, 2);
        check("hit_frozen_st", game_status, 0);

        // Hit together with the start press: stays stopped.
        repeat (6) cycle(1, 1);
        check("hit_press", game_status, 0);
        repeat (6) cycle(0, 0);

        // Random play.
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            logic btn;
            len = $urandom_range(1, 10);
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cur_sw = 16'($urandom);
            for (int k = 0; k < len; k++) cycle(btn, $urandom_range(0, 299) == 0);
        end

        // Asynchronous reset mid-jump.
        for (int i = 0; i < 80 && dinosaur_height != 6'd2; i++) cycle((i % 10) < 5, 0);
        check("reach_h2_rst", dinosaur_height, 2);
        #2 clrn = 1'b0;
        m_reset();
        #1;
        check("arst_height", dinosaur_height, 0);
        check("arst_status", game_status, 0);
        check("arst_speed", speed, 0);
        check("arst_position", ground_position, 0);
        check("arst_sw_ok", SW_OK, 0);
        @(negedge CLK);
        clrn = 1'b1;
        repeat (10) cycle(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
